// File: rtl/riscv_m_pkg.sv
// Shared types and helpers for the RV32M/RV64M execute unit.
package riscv_m_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } m_func3_e;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        ITER,
        FIX,
        HOLD
    } div_state_e;

    localparam int unsigned CLZ_W = 7;

    // Leading-zero count of a 64-bit word; returns 64 for zero.
    function automatic logic [CLZ_W-1:0] clz64(input logic [63:0] x);
        logic [CLZ_W-1:0] n;
        logic             found;
        n     = CLZ_W'(64);
        found = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (!found && x[i]) begin
                n     = CLZ_W'(63 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/riscv_m_divider.sv
// Iterative radix-2 restoring divider with leading-zero early-out,
// divide-by-zero/overflow fast paths and a last-result cache.
module riscv_m_divider
    import riscv_m_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             i_start,
    input  logic             i_sgn,
    input  logic             i_rem,
    input  logic [XLEN-1:0]  i_rs1,
    input  logic [XLEN-1:0]  i_rs2,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_stall,
    output logic             o_busy,
    output logic             o_done_c,
    output logic [XLEN-1:0]  o_res_c,
    output logic [TAG_W-1:0] o_tag
);

    localparam int unsigned CW = $clog2(XLEN) + 1;

    div_state_e       r_state;
    logic             r_busy, r_sgn, r_rem_op;
    logic [XLEN-1:0]  r_a, r_b, r_dvd, r_rmd, r_babs, r_res;
    logic [TAG_W-1:0] r_tag;
    logic [CW-1:0]    r_cnt;
    logic             r_c_v, r_c_sgn;
    logic [XLEN-1:0]  r_c_a, r_c_b, r_c_q, r_c_r;

    logic             w_dz, w_ovf, w_hit, w_neg_a, w_neg_b, w_ge;
    logic [XLEN-1:0]  w_fast_res, w_abs_a, w_abs_b, w_sub, w_q_fix, w_r_fix, w_fix_res;
    logic [XLEN:0]    w_sh;
    logic [CLZ_W-1:0] w_clz;
    logic [CW-1:0]    w_n;

    // Fast-path detection on the issuing operands
    assign w_dz  = (i_rs2 == '0);
    assign w_ovf = i_sgn && (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&i_rs2);
    assign w_hit = r_c_v && (i_rs1 == r_c_a) && (i_rs2 == r_c_b) && (i_sgn == r_c_sgn);
    assign w_fast_res = w_dz  ? (i_rem ? i_rs1 : '1) :
                        w_ovf ? (i_rem ? '0 : i_rs1) :
                                (i_rem ? r_c_r : r_c_q);

    // Normalisation: magnitudes and significant-bit count of the dividend
    assign w_neg_a = r_sgn && r_a[XLEN-1];
    assign w_neg_b = r_sgn && r_b[XLEN-1];
    assign w_abs_a = w_neg_a ? -r_a : r_a;
    assign w_abs_b = w_neg_b ? -r_b : r_b;
    assign w_clz   = clz64(64'(w_abs_a) << (64 - XLEN));
    assign w_n     = (w_abs_a == '0) ? CW'(1) : CW'(CLZ_W'(XLEN) - w_clz);

    // One restoring step; partial remainder always stays below the divisor
    assign w_sh  = {r_rmd, r_dvd[XLEN-1]};
    assign w_ge  = (w_sh >= {1'b0, r_babs});
    assign w_sub = w_sh[XLEN-1:0] - r_babs;

    assign w_q_fix   = (r_sgn && (r_a[XLEN-1] ^ r_b[XLEN-1])) ? -r_dvd : r_dvd;
    assign w_r_fix   = w_neg_a ? -r_rmd : r_rmd;
    assign w_fix_res = r_rem_op ? w_r_fix : w_q_fix;

    assign o_busy   = r_busy;
    assign o_done_c = (r_state == FIX) || (r_state == HOLD);
    assign o_res_c  = (r_state == HOLD) ? r_res : w_fix_res;
    assign o_tag    = r_tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_sgn    <= 1'b0;
            r_rem_op <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_dvd    <= '0;
            r_rmd    <= '0;
            r_babs   <= '0;
            r_res    <= '0;
            r_tag    <= '0;
            r_cnt    <= '0;
            r_c_v    <= 1'b0;
            r_c_sgn  <= 1'b0;
            r_c_a    <= '0;
            r_c_b    <= '0;
            r_c_q    <= '0;
            r_c_r    <= '0;
        end else if (flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_a      <= i_rs1;
                        r_b      <= i_rs2;
                        r_sgn    <= i_sgn;
                        r_rem_op <= i_rem;
                        r_tag    <= i_tag;
                        r_busy   <= 1'b1;
                        if (w_dz || w_ovf || w_hit) begin
                            r_res   <= w_fast_res;
                            r_state <= HOLD;
                        end else begin
                            r_state <= NORM;
                        end
                    end
                end
                NORM: begin
                    r_dvd   <= w_abs_a << w_clz;
                    r_rmd   <= '0;
                    r_babs  <= w_abs_b;
                    r_cnt   <= w_n;
                    r_state <= ITER;
                end
                ITER: begin
                    r_dvd <= {r_dvd[XLEN-2:0], w_ge};
                    r_rmd <= w_ge ? w_sub : w_sh[XLEN-1:0];
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) r_state <= FIX;
                end
                FIX: begin
                    r_c_v   <= 1'b1;
                    r_c_a   <= r_a;
                    r_c_b   <= r_b;
                    r_c_sgn <= r_sgn;
                    r_c_q   <= w_q_fix;
                    r_c_r   <= w_r_fix;
                    if (i_stall) begin
                        r_res   <= w_fix_res;
                        r_state <= HOLD;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                HOLD: begin
                    if (!i_stall) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/riscv_m_unit_pipe.sv
// RV32M/RV64M execute unit: pipelined multiplier, iterative divider and
// a shared registered result port where multiplies take priority.
module riscv_m_unit_pipe
    import riscv_m_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned TAG_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [2:0]       func3,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [TAG_W-1:0] tag,
    input  logic             flush,
    output logic             busy,
    output logic             ready,
    output logic             wr,
    output logic [XLEN-1:0]  rd,
    output logic [TAG_W-1:0] rd_tag
);

    logic              w_accept, w_issue_mul, w_issue_div, w_sa, w_sb, w_mul_v;
    logic [2*XLEN-1:0] w_ma, w_mb, w_prod;
    logic [XLEN-1:0]   w_mul_res, w_mul_d, w_div_res;
    logic [TAG_W-1:0]  w_mul_t, w_div_tag;
    logic              w_div_done, w_div_busy;

    assign w_accept    = valid && !w_div_busy && !flush;
    assign w_issue_mul = w_accept && !func3[2];
    assign w_issue_div = w_accept &&  func3[2];

    // Sign-extend both operands to 2*XLEN; low 2*XLEN product bits are exact
    assign w_sa      = (func3 == MULH) || (func3 == MULHSU);
    assign w_sb      = (func3 == MULH);
    assign w_ma      = {{XLEN{w_sa & rs1[XLEN-1]}}, rs1};
    assign w_mb      = {{XLEN{w_sb & rs2[XLEN-1]}}, rs2};
    assign w_prod    = w_ma * w_mb;
    assign w_mul_res = (func3 == MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    if (MUL_STAGES > 1) begin : g_pipe
        localparam int unsigned D = MUL_STAGES - 1;
        logic             r_pv [D];
        logic [XLEN-1:0]  r_pd [D];
        logic [TAG_W-1:0] r_pt [D];

        always_ff @(posedge clk) begin
            if (reset || flush) begin
                for (int i = 0; i < D; i++) r_pv[i] <= 1'b0;
            end else begin
                r_pv[0] <= w_issue_mul;
                for (int i = 1; i < D; i++) r_pv[i] <= r_pv[i-1];
            end
            r_pd[0] <= w_mul_res;
            r_pt[0] <= tag;
            for (int i = 1; i < D; i++) begin
                r_pd[i] <= r_pd[i-1];
                r_pt[i] <= r_pt[i-1];
            end
        end

        assign w_mul_v = r_pv[D-1];
        assign w_mul_d = r_pd[D-1];
        assign w_mul_t = r_pt[D-1];
    end else begin : g_comb
        assign w_mul_v = w_issue_mul;
        assign w_mul_d = w_mul_res;
        assign w_mul_t = tag;
    end

    riscv_m_divider #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .i_start  (w_issue_div),
        .i_sgn    (!func3[0]),
        .i_rem    (func3[1]),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .i_tag    (tag),
        .i_stall  (w_mul_v),
        .o_busy   (w_div_busy),
        .o_done_c (w_div_done),
        .o_res_c  (w_div_res),
        .o_tag    (w_div_tag)
    );

    assign busy = w_div_busy;

    // Result port: multiply wins, the divider retries from HOLD
    always_ff @(posedge clk) begin
        if (reset) begin
            ready  <= 1'b0;
            wr     <= 1'b0;
            rd     <= '0;
            rd_tag <= '0;
        end else if (flush) begin
            ready <= 1'b0;
            wr    <= 1'b0;
        end else if (w_mul_v) begin
            ready  <= 1'b1;
            wr     <= (w_mul_t != '0);
            rd     <= w_mul_d;
            rd_tag <= w_mul_t;
        end else if (w_div_done) begin
            ready  <= 1'b1;
            wr     <= (w_div_tag != '0);
            rd     <= w_div_res;
            rd_tag <= w_div_tag;
        end else begin
            ready <= 1'b0;
            wr    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_m_unit_pipe.sv
// Directed bench: XLEN=32/MUL_STAGES=2, XLEN=32/MUL_STAGES=3 and XLEN=64 instances.
module tb_riscv_m_unit_pipe;
    import riscv_m_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_valid, a_flush, a_busy, a_ready, a_wr;
    logic [2:0]  a_func3;
    logic [31:0] a_rs1, a_rs2, a_rd;
    logic [4:0]  a_tag, a_rd_tag;

    logic        b_valid, b_flush, b_busy, b_ready, b_wr;
    logic [2:0]  b_func3;
    logic [31:0] b_rs1, b_rs2, b_rd;
    logic [4:0]  b_tag, b_rd_tag;

    logic        c_valid, c_flush, c_busy, c_ready, c_wr;
    logic [2:0]  c_func3;
    logic [63:0] c_rs1, c_rs2, c_rd;
    logic [4:0]  c_tag, c_rd_tag;

    riscv_m_unit_pipe #(.XLEN(32), .MUL_STAGES(2), .TAG_W(5)) dut_a (
        .clk(clk), .reset(reset), .valid(a_valid), .func3(a_func3), .rs1(a_rs1), .rs2(a_rs2),
        .tag(a_tag), .flush(a_flush), .busy(a_busy), .ready(a_ready), .wr(a_wr), .rd(a_rd),
        .rd_tag(a_rd_tag));

    riscv_m_unit_pipe #(.XLEN(32), .MUL_STAGES(3), .TAG_W(5)) dut_b (
        .clk(clk), .reset(reset), .valid(b_valid), .func3(b_func3), .rs1(b_rs1), .rs2(b_rs2),
        .tag(b_tag), .flush(b_flush), .busy(b_busy), .ready(b_ready), .wr(b_wr), .rd(b_rd),
        .rd_tag(b_rd_tag));

    riscv_m_unit_pipe #(.XLEN(64), .MUL_STAGES(2), .TAG_W(5)) dut_c (
        .clk(clk), .reset(reset), .valid(c_valid), .func3(c_func3), .rs1(c_rs1), .rs2(c_rs2),
        .tag(c_tag), .flush(c_flush), .busy(c_busy), .ready(c_ready), .wr(c_wr), .rd(c_rd),
        .rd_tag(c_rd_tag));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic a_issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                           input logic [4:0] t);
        a_valid = 1'b1; a_func3 = f; a_rs1 = x; a_rs2 = y; a_tag = t;
    endtask

    task automatic a_res(input string name, input logic [31:0] exp_rd, input logic [4:0] exp_tag);
        chk({name, "_ready"}, 64'(a_ready), 64'd1);
        chk({name, "_rd"}, 64'(a_rd), 64'(exp_rd));
        chk({name, "_tag"}, 64'(a_rd_tag), 64'(exp_tag));
        chk({name, "_wr"}, 64'(a_wr), 64'(exp_tag != 5'd0));
    endtask

    initial begin
        reset = 1'b1;
        a_valid = 1'b0; a_flush = 1'b0; a_func3 = 3'd0; a_rs1 = '0; a_rs2 = '0; a_tag = '0;
        b_valid = 1'b0; b_flush = 1'b0; b_func3 = 3'd0; b_rs1 = '0; b_rs2 = '0; b_tag = '0;
        c_valid = 1'b0; c_flush = 1'b0; c_func3 = 3'd0; c_rs1 = '0; c_rs2 = '0; c_tag = '0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_ready", 64'(a_ready), 64'd0);
        chk("rst_wr", 64'(a_wr), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_rd", 64'(a_rd), 64'd0);
        chk("rst_tag", 64'(a_rd_tag), 64'd0);
        chk("rst_c_rd", c_rd, 64'd0);

        // Back-to-back MUL / MULHU
        a_issue(MUL, 32'h1111FFFF, 32'h1111FFFF, 5'd3);
        tick();
        chk("mul_busy", 64'(a_busy), 64'd0);
        a_issue(MULHU, 32'h1111FFFF, 32'h1111FFFF, 5'd4);
        tick();
        a_valid = 1'b0;
        a_res("mul_lo", 32'hDDDC0001, 5'd3);
        tick();
        a_res("mulhu", 32'h01236543, 5'd4);
        chk("mulhu_busy", 64'(a_busy), 64'd0);
        tick();
        chk("mul_idle_ready", 64'(a_ready), 64'd0);
        chk("mul_hold_rd", 64'(a_rd), 64'h01236543);

        // Long DIVU 13/5, n=4 -> ready in cycle 7
        a_issue(DIVU, 32'd13, 32'd5, 5'd7);
        tick();
        a_valid = 1'b0;
        chk("divu_busy_c1", 64'(a_busy), 64'd1);
        repeat (5) tick();
        chk("divu_c6_ready", 64'(a_ready), 64'd0);
        chk("divu_c6_busy", 64'(a_busy), 64'd1);
        tick();
        a_res("divu", 32'd2, 5'd7);
        chk("divu_c7_busy", 64'(a_busy), 64'd0);

        // REMU same operands -> cache hit in cycle 2
        a_issue(REMU, 32'd13, 32'd5, 5'd8);
        tick();
        a_valid = 1'b0;
        chk("remu_c1_ready", 64'(a_ready), 64'd0);
        tick();
        a_res("remu_hit", 32'd3, 5'd8);

        // Divide by zero and signed overflow fast paths
        a_issue(DIV, 32'hFFFFFFF3, 32'd0, 5'd0);
        tick();
        a_valid = 1'b0;
        tick();
        a_res("div_zero", 32'hFFFFFFFF, 5'd0);
        a_issue(REM, 32'h80000000, 32'hFFFFFFFF, 5'd9);
        tick();
        a_valid = 1'b0;
        tick();
        a_res("rem_ovf", 32'h00000000, 5'd9);

        // Long DIV, blocked MUL, flush in cycle 10
        a_issue(DIV, 32'h80000001, 32'd7, 5'd10);
        tick();
        a_issue(MUL, 32'd3, 32'd4, 5'd11);
        for (int c = 1; c < 10; c++) begin
            chk("flush_noready", 64'(a_ready), 64'd0);
            tick();
        end
        chk("flush_c10_busy", 64'(a_busy), 64'd1);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        a_valid = 1'b0;
        chk("flush_c11_busy", 64'(a_busy), 64'd0);
        chk("flush_c11_ready", 64'(a_ready), 64'd0);
        tick();
        chk("flush_c12_ready", 64'(a_ready), 64'd0);
        chk("flush_rd_kept", 64'(a_rd), 64'd0);
        chk("flush_tag_kept", 64'(a_rd_tag), 64'd9);

        // DIV 34 / -23 -> -1 (n=6, cycle 9), then REM via cache -> 11
        a_issue(DIV, 32'd34, 32'hFFFFFFE9, 5'd12);
        tick();
        a_valid = 1'b0;
        repeat (7) tick();
        chk("sdiv_c8_ready", 64'(a_ready), 64'd0);
        tick();
        a_res("sdiv", 32'hFFFFFFFF, 5'd12);
        a_issue(REM, 32'd34, 32'hFFFFFFE9, 5'd13);
        tick();
        a_valid = 1'b0;
        tick();
        a_res("srem_hit", 32'd11, 5'd13);

        // REM -7 / 2 -> -1 (n=3, cycle 6), then DIV via cache -> -3
        a_issue(REM, 32'hFFFFFFF9, 32'd2, 5'd14);
        tick();
        a_valid = 1'b0;
        repeat (4) tick();
        chk("nrem_c5_ready", 64'(a_ready), 64'd0);
        tick();
        a_res("nrem", 32'hFFFFFFFF, 5'd14);
        a_issue(DIV, 32'hFFFFFFF9, 32'd2, 5'd15);
        tick();
        a_valid = 1'b0;
        tick();
        a_res("ndiv_hit", 32'hFFFFFFFD, 5'd15);

        // Collision with MUL_STAGES=3: MUL wins cycle 3, divide deferred to cycle 4
        b_valid = 1'b1; b_func3 = MUL; b_rs1 = 32'd6; b_rs2 = 32'd7; b_tag = 5'd1;
        tick();
        b_func3 = DIVU; b_rs1 = 32'd5; b_rs2 = 32'd0; b_tag = 5'd2;
        tick();
        b_valid = 1'b0;
        chk("col_c2_busy", 64'(b_busy), 64'd1);
        tick();
        chk("col_c3_ready", 64'(b_ready), 64'd1);
        chk("col_c3_rd", 64'(b_rd), 64'h2A);
        chk("col_c3_tag", 64'(b_rd_tag), 64'd1);
        chk("col_c3_busy", 64'(b_busy), 64'd1);
        tick();
        chk("col_c4_ready", 64'(b_ready), 64'd1);
        chk("col_c4_rd", 64'(b_rd), 64'hFFFFFFFF);
        chk("col_c4_tag", 64'(b_rd_tag), 64'd2);
        chk("col_c4_busy", 64'(b_busy), 64'd0);
        tick();
        chk("col_c5_ready", 64'(b_ready), 64'd0);

        // XLEN=64: MULH -1 x 2, then DIVU 2^63/3 with tag 0 (n=64, cycle 67)
        c_valid = 1'b1; c_func3 = MULH; c_rs1 = 64'hFFFFFFFFFFFFFFFF; c_rs2 = 64'd2; c_tag = 5'd5;
        tick();
        c_valid = 1'b0;
        tick();
        chk("c_mulh_ready", 64'(c_ready), 64'd1);
        chk("c_mulh_rd", c_rd, 64'hFFFFFFFFFFFFFFFF);
        c_valid = 1'b1; c_func3 = DIVU; c_rs1 = 64'h8000000000000000; c_rs2 = 64'd3; c_tag = 5'd0;
        tick();
        c_valid = 1'b0;
        repeat (65) tick();
        chk("c_div_c66_ready", 64'(c_ready), 64'd0);
        chk("c_div_c66_busy", 64'(c_busy), 64'd1);
        tick();
        chk("c_div_ready", 64'(c_ready), 64'd1);
        chk("c_div_rd", c_rd, 64'h2AAAAAAAAAAAAAAA);
        chk("c_div_wr", 64'(c_wr), 64'd0);
        chk("c_div_busy", 64'(c_busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
